// File: rtl/branch_scanner_if.sv
// ---------------------------------------------------------------------------
// branch_scanner_if
//   Bundles the decode-side signals exchanged with the branch scanner.
//   master : fetch/decode side. Drives instruction, instr_valid and acc_zero;
//            observes the scan outputs.
//   slave  : branch scanner. Consumes the instruction stream and drives
//            pc_step, pc_dir, scanning, branch_done, depth and error.
// ---------------------------------------------------------------------------
interface branch_scanner_if #(
    parameter int OP_W    = 8,
    parameter int DEPTH_W = 8
);
    logic [OP_W-1:0]    instruction;
    logic               instr_valid;
    logic               acc_zero;
    logic               pc_step;
    logic               pc_dir;
    logic               scanning;
    logic               branch_done;
    logic [DEPTH_W-1:0] depth;
    logic               error;

    modport master (
        output instruction, instr_valid, acc_zero,
        input  pc_step, pc_dir, scanning, branch_done, depth, error
    );

    modport slave (
        input  instruction, instr_valid, acc_zero,
        output pc_step, pc_dir, scanning, branch_done, depth, error
    );
endinterface

// File: rtl/branch_scanner.sv
// ---------------------------------------------------------------------------
// branch_scanner
//   Sequencer for BeeF conditional branches. A taken CBF (acc zero) or CBB
//   (acc non-zero) starts a scan that walks the PC one slot per step in the
//   branch direction, counting bracket nesting until the matching bracket is
//   under the PC. Normal decode is suppressed while scanning.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   bus.instruction / bus.instr_valid   op_code at current PC, qualified
//   bus.acc_zero current data cell is zero (only looked at while idle)
//   bus.pc_step  one-cycle pulse: move PC one slot in direction pc_dir
//   bus.pc_dir   0 = forward, 1 = backward
//   bus.scanning scan in progress
//   bus.branch_done one-cycle pulse: PC rests on the matching bracket
//   bus.depth    current nesting depth
//   bus.error    sticky depth overflow, cleared only by reset
// ---------------------------------------------------------------------------
module branch_scanner #(
    parameter int              OP_W    = 8,
    parameter int              DEPTH_W = 8,
    parameter logic [OP_W-1:0] CBF_OP  = OP_W'(8'h5B),
    parameter logic [OP_W-1:0] CBB_OP  = OP_W'(8'h5D)
) (
    input  logic             clock,
    input  logic             reset,
    branch_scanner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [DEPTH_W-1:0] depth_q, depth_nxt;
    logic               dir_q, dir_nxt;
    // Set for the first IDLE cycle after DONE: the matching bracket may still
    // be presented then and must not be taken as a new branch.
    logic               skip_q, skip_nxt;

    logic               is_same, is_opp;

    // Bracket classification relative to the current scan direction.
    always_comb begin
        is_same = 1'b0;
        is_opp  = 1'b0;
        if (dir_q) begin
            is_same = (bus.instruction == CBB_OP);
            is_opp  = (bus.instruction == CBF_OP);
        end else begin
            is_same = (bus.instruction == CBF_OP);
            is_opp  = (bus.instruction == CBB_OP);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            depth_q <= '0;
            dir_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            depth_q <= depth_nxt;
            dir_q   <= dir_nxt;
            skip_q  <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        depth_nxt = depth_q;
        dir_nxt   = dir_q;
        skip_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!skip_q && bus.instr_valid) begin
                    if (bus.instruction == CBF_OP && bus.acc_zero) begin
                        state_nxt = STEP;
                        dir_nxt   = 1'b0;
                        depth_nxt = DEPTH_W'(1);
                    end else if (bus.instruction == CBB_OP && !bus.acc_zero) begin
                        state_nxt = STEP;
                        dir_nxt   = 1'b1;
                        depth_nxt = DEPTH_W'(1);
                    end
                end
            end

            STEP: state_nxt = WAIT;

            WAIT: begin
                if (bus.instr_valid) begin
                    if (is_same) begin
                        // Nesting deeper than the counter can hold is fatal.
                        if (depth_q == '1) begin
                            state_nxt = ERROR;
                        end else begin
                            depth_nxt = depth_q + DEPTH_W'(1);
                            state_nxt = STEP;
                        end
                    end else if (is_opp) begin
                        depth_nxt = depth_q - DEPTH_W'(1);
                        state_nxt = (depth_q == DEPTH_W'(1)) ? DONE : STEP;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                depth_nxt = '0;
                dir_nxt   = 1'b0;
                skip_nxt  = 1'b1;
            end

            ERROR: state_nxt = ERROR;

            default: begin
                state_nxt = IDLE;
                depth_nxt = '0;
                dir_nxt   = 1'b0;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register.
    assign bus.pc_step     = (state == STEP);
    assign bus.scanning    = (state == STEP) || (state == WAIT) || (state == DONE);
    assign bus.branch_done = (state == DONE);
    assign bus.error       = (state == ERROR);
    assign bus.depth       = depth_q;
    assign bus.pc_dir      = dir_q;

endmodule
